// File: rtl/mod_mult_pkg.sv
// Shared widths and the tag carried alongside each multiplier operation.
package mod_mult_pkg;
  localparam int DATA_W      = 64;
  localparam int K_W         = 7;
  localparam int U_W         = 128;
  localparam int LAT_DEFAULT = 19;
  localparam int ID_W        = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/mod_mult_arbiter_64b_rr.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          iClk,
  input  logic          iClr,
  input  logic          iAccept,
  input  logic [N-1:0]  iReq,
  output logic [N-1:0]  oGnt,
  output logic [IW-1:0] oIdx
);
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_j;
  logic          w_hit;

  always_comb begin
    oGnt  = '0;
    oIdx  = '0;
    w_hit = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(r_ptr) + k) % N);
      if (!w_hit && iReq[w_j]) begin
        w_hit = 1'b1;
        oIdx  = w_j;
      end
    end
    oGnt[oIdx] = w_hit;
  end

  always_ff @(posedge iClk) begin
    if (iClr)
      r_ptr <= '0;
    else if (iAccept)
      r_ptr <= (oIdx == IW'(N-1)) ? '0 : oIdx + 1'b1;
  end
endmodule

// File: rtl/mod_mult_arbiter_64b.sv
// Shares one pipelined Barrett multiplier among NUM_REQ requesters.
// Define MOD_MULT_ARB_PERF_EN to add issue/stall counters.
module mod_mult_arbiter_64b
  import mod_mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = LAT_DEFAULT,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iFlush,
  input  logic                      iCfgWe,
  output logic                      oCfgReady,
  input  logic [K_W-1:0]            iCfgK,
  input  logic [U_W-1:0]            iCfgU,
  input  logic [DATA_W-1:0]         iCfgMod,
  input  logic [NUM_REQ-1:0]        iReqValid,
  output logic [NUM_REQ-1:0]        oReqReady,
  input  logic [NUM_REQ*DATA_W-1:0] iReqData0,
  input  logic [NUM_REQ*DATA_W-1:0] iReqData1,
  output logic                      oMulEn,
  output logic                      oMulClr,
  output logic [K_W-1:0]            oMulK,
  output logic [U_W-1:0]            oMulU,
  output logic [DATA_W-1:0]         oMulMod,
  output logic [DATA_W-1:0]         oMulData0,
  output logic [DATA_W-1:0]         oMulData1,
  input  logic [DATA_W-1:0]         iMulData,
  output logic                      oRspValid,
  output logic [IW-1:0]             oRspId,
  output logic [DATA_W-1:0]         oRspData,
  output logic                      oBusy
`ifdef MOD_MULT_ARB_PERF_EN
  ,
  output logic [31:0]               oIssueCnt,
  output logic [31:0]               oStallCnt
`endif
);
  tag_t              r_tag [LATENCY];
  logic              r_cfgd;
  logic              r_en;
  logic              r_clr;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [K_W-1:0]    r_k;
  logic [U_W-1:0]    r_u;
  logic [DATA_W-1:0] r_mod;
  logic [DATA_W-1:0] r_d0;
  logic [DATA_W-1:0] r_d1;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_empty;
  logic               w_block;
  logic               w_acc;
  logic               w_cfg_fire;
  logic               w_unused_id;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  tag_t               w_tag_in;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .iClk    (iClk),
    .iClr    (iRst | iFlush),
    .iAccept (w_acc),
    .iReq    (iReqValid),
    .oGnt    (w_gnt),
    .oIdx    (w_idx)
  );

  always_comb begin
    w_empty = 1'b1;
    for (int i = 0; i < LATENCY; i++)
      if (r_tag[i].valid) w_empty = 1'b0;
  end

  // A config write to an idle pipe takes priority over any grant.
  assign w_block    = iRst | iFlush | ~r_cfgd
                    | (iCfgWe & w_empty);
  assign oReqReady  = w_block ? '0 : w_gnt;
  assign w_acc      = |oReqReady;
  assign oCfgReady  = ~iRst & w_empty & ~w_acc;
  assign w_cfg_fire = iCfgWe & oCfgReady;

  assign w_a = iReqData0[int'(w_idx)*DATA_W +: DATA_W];
  assign w_b = iReqData1[int'(w_idx)*DATA_W +: DATA_W];

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_acc;
    w_tag_in.id    = w_acc ? ID_W'(w_idx) : '0;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_cfgd      <= 1'b0;
      r_en        <= 1'b0;
      r_clr       <= 1'b1;
      r_k         <= '0;
      r_u         <= '0;
      r_mod       <= '0;
      r_d0        <= '0;
      r_d1        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      for (int i = 0; i < LATENCY; i++)
        r_tag[i] <= '0;
    end else begin
      r_en  <= 1'b1;
      r_clr <= iFlush;
      if (w_cfg_fire) begin
        r_k    <= iCfgK;
        r_u    <= iCfgU;
        r_mod  <= iCfgMod;
        r_cfgd <= 1'b1;
      end
      r_d0     <= w_acc ? w_a : '0;
      r_d1     <= w_acc ? w_b : '0;
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < LATENCY; i++)
        r_tag[i] <= iFlush ? '0 : r_tag[i-1];
      r_rsp_valid <= r_tag[LATENCY-1].valid & ~iFlush;
      r_rsp_id    <= r_tag[LATENCY-1].id;
    end
  end

  assign oMulEn      = r_en;
  assign oMulClr     = r_clr;
  assign oMulK       = r_k;
  assign oMulU       = r_u;
  assign oMulMod     = r_mod;
  assign oMulData0   = r_d0;
  assign oMulData1   = r_d1;
  assign oRspValid   = r_rsp_valid & ~iRst;
  assign oRspId      = oRspValid ? r_rsp_id[IW-1:0] : '0;
  assign oRspData    = oRspValid ? iMulData : '0;
  assign oBusy       = ~w_empty & ~iRst;
  assign w_unused_id = &r_rsp_id;

`ifdef MOD_MULT_ARB_PERF_EN
  logic [31:0] r_issue;
  logic [31:0] r_stall;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_issue <= '0;
      r_stall <= '0;
    end else begin
      if (w_acc && r_issue != '1)
        r_issue <= r_issue + 1'b1;
      if (|iReqValid && !w_acc && r_stall != '1)
        r_stall <= r_stall + 1'b1;
    end
  end

  assign oIssueCnt = r_issue;
  assign oStallCnt = r_stall;
`endif
endmodule
